fpdiv_seq: RTL and testbench

FPDIV_SEQ -- requirements
Module: fpdiv_seq

---
 rtl/fpdiv_seq.sv | 174 +++++++++++++++++
 tb/tb_fpdiv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_seq.sv
// Sequencer for a Goldschmidt floating-point divider: walks the datapath through a
// fixed step program, giving each multiplier step MUL_LAT settle cycles before its strobe.
module fpdiv_seq #(
    parameter int ITER    = 3,
    parameter int MUL_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] rm_in,
    output logic       ready,
    output logic       busy,
    output logic       ld,
    output logic [1:0] sel_muxa,
    output logic [1:0] sel_muxb,
    output logic       enA,
    output logic       enB,
    output logic       enC,
    output logic       enR,
    output logic [1:0] rm_out,
    output logic       done,
    output logic [2:0] iter_idx
);
    // Wide enough for the largest program (ITER=7 gives 18 steps), so it never wraps.
    localparam int STEP_W = 5;
    localparam logic [STEP_W-1:0] FIN_STEP    = STEP_W'(2 * ITER + 2);
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(2 * ITER + 3);
    localparam logic [2:0]        SETTLE_LAST = 3'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        STROBE = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;
    logic [2:0]        r_settle;
    logic [2:0]        w_settle_nxt;
    logic [1:0]        r_rm;
    logic              w_accept;
    logic [3:0]        w_strb;

    // State, step and settle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_step   <= '0;
            r_settle <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    // Rounding mode captured at accept and held for the whole operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rm <= 2'b00;
        end else if (w_accept) begin
            r_rm <= rm_in;
        end else begin
            r_rm <= r_rm;
        end
    end

    // Next-state logic; abort from SETUP/STROBE drops straight back to IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_settle_nxt = r_settle;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                w_step_nxt   = '0;
                w_settle_nxt = 3'd0;
                if (start && !abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (abort) begin
                    w_state_nxt  = IDLE;
                    w_step_nxt   = '0;
                    w_settle_nxt = 3'd0;
                end else if (r_settle == SETTLE_LAST) begin
                    w_state_nxt  = STROBE;
                    w_settle_nxt = 3'd0;
                end else begin
                    w_settle_nxt = r_settle + 3'd1;
                end
            end
            STROBE: begin
                w_settle_nxt = 3'd0;
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_step_nxt  = '0;
                end else if (r_step == LAST_STEP) begin
                    w_state_nxt = DONE;
                    w_step_nxt  = '0;
                end else begin
                    w_state_nxt = SETUP;
                    w_step_nxt  = r_step + STEP_W'(1);
                end
            end
            DONE: begin
                w_state_nxt  = IDLE;
                w_step_nxt   = '0;
                w_settle_nxt = 3'd0;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_step_nxt   = '0;
                w_settle_nxt = 3'd0;
            end
        endcase
    end

    // Step program decode; strobe group order is {A, B, C, R}.
    always_comb begin
        sel_muxa = 2'b10;
        sel_muxb = 2'b01;
        w_strb   = 4'b0000;
        iter_idx = 3'd0;
        if (r_state == SETUP || r_state == STROBE) begin
            if (r_step == STEP_W'(0)) begin
                sel_muxa = 2'b10;
                sel_muxb = 2'b01;
                w_strb   = 4'b0100;
            end else if (r_step == STEP_W'(1)) begin
                sel_muxa = 2'b10;
                sel_muxb = 2'b00;
                w_strb   = 4'b1010;
            end else if (r_step == FIN_STEP) begin
                sel_muxa = 2'b00;
                sel_muxb = 2'b10;
                w_strb   = 4'b0100;
            end else if (r_step == LAST_STEP) begin
                sel_muxa = 2'b01;
                sel_muxb = 2'b10;
                w_strb   = 4'b0001;
            end else begin
                // Refinement pair i occupies steps 2i and 2i+1.
                sel_muxa = 2'b00;
                sel_muxb = r_step[0] ? 2'b11 : 2'b10;
                w_strb   = r_step[0] ? 4'b1010 : 4'b0100;
                iter_idx = r_step[3:1];
            end
        end else begin
            sel_muxa = 2'b10;
            sel_muxb = 2'b01;
            w_strb   = 4'b0000;
            iter_idx = 3'd0;
        end
    end

    assign enA    = (r_state == STROBE) && w_strb[3];
    assign enB    = (r_state == STROBE) && w_strb[2];
    assign enC    = (r_state == STROBE) && w_strb[1];
    assign enR    = (r_state == STROBE) && w_strb[0];
    assign ready  = (r_state == IDLE);
    assign busy   = (r_state == SETUP) || (r_state == STROBE);
    assign done   = (r_state == DONE);
    assign ld     = w_accept;
    assign rm_out = r_rm;
endmodule

// File: tb/tb_fpdiv_seq.sv
// Self-checking bench for fpdiv_seq: a default instance and an ITER=1/MUL_LAT=3 instance,
// each compared cycle by cycle against a trace built from the step program.
module tb_fpdiv_seq;
    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       st [2];
    logic       ab [2];
    logic [1:0] rm_in;
    logic       rdy [2];
    logic       bsy [2];
    logic       ldo [2];
    logic       dn  [2];
    logic       ea  [2];
    logic       eb  [2];
    logic       ec  [2];
    logic       er  [2];
    logic [1:0] sa  [2];
    logic [1:0] sb  [2];
    logic [1:0] rmo [2];
    logic [2:0] it  [2];
    logic [1:0] last_rm [2];
    int n_checks = 0;
    int n_fail   = 0;

    // {ready, busy, ld, done, sel_a, sel_b, enA, enB, enC, enR, rm_out, iter_idx}
    localparam logic [16:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0000, 2'b00, 3'd0};

    always #5 clk = ~clk;

    fpdiv_seq u_dut0 (
        .clk(clk), .reset(reset), .start(st[0]), .abort(ab[0]), .rm_in(rm_in),
        .ready(rdy[0]), .busy(bsy[0]), .ld(ldo[0]), .sel_muxa(sa[0]), .sel_muxb(sb[0]),
        .enA(ea[0]), .enB(eb[0]), .enC(ec[0]), .enR(er[0]), .rm_out(rmo[0]),
        .done(dn[0]), .iter_idx(it[0])
    );

    fpdiv_seq #(.ITER(1), .MUL_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(st[1]), .abort(ab[1]), .rm_in(rm_in),
        .ready(rdy[1]), .busy(bsy[1]), .ld(ldo[1]), .sel_muxa(sa[1]), .sel_muxb(sb[1]),
        .enA(ea[1]), .enB(eb[1]), .enC(ec[1]), .enR(er[1]), .rm_out(rmo[1]),
        .done(dn[1]), .iter_idx(it[1])
    );

    function automatic logic [16:0] obs(input int d);
        return {rdy[d], bsy[d], ldo[d], dn[d], sa[d], sb[d], ea[d], eb[d], ec[d], er[d], rmo[d], it[d]};
    endfunction

    // Step s of the program as {sel_a, sel_b, {A,B,C,R}, iter}, built as an explicit list.
    function automatic logic [10:0] step_info(input int itr, input int s);
        logic [10:0] q[$];
        q.push_back({2'b10, 2'b01, 4'b0100, 3'd0});
        q.push_back({2'b10, 2'b00, 4'b1010, 3'd0});
        for (int i = 1; i <= itr; i++) begin
            q.push_back({2'b00, 2'b10, 4'b0100, 3'(i)});
            q.push_back({2'b00, 2'b11, 4'b1010, 3'(i)});
        end
        q.push_back({2'b00, 2'b10, 4'b0100, 3'd0});
        q.push_back({2'b01, 2'b10, 4'b0001, 3'd0});
        return q[s];
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got %h expected %h", d, obs(d), RST_VEC);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_rm[0] = 2'b00;
        last_rm[1] = 2'b00;
    endtask

    // One operation on instance d; abort_t >= 0 raises abort in that cycle (t=0 is accept).
    task automatic test_operation(input int d, input logic [1:0] rm, input int abort_t);
        int itr  = (d != 0) ? 1 : 3;
        int ml   = (d != 0) ? 3 : 1;
        int body = (2 * itr + 4) * (ml + 1);
        int last = (abort_t >= 0) ? abort_t + 2 : body + 2;
        int u;
        logic [10:0] e;
        logic [16:0] exp_v;
        @(posedge clk); #1;
        st[d] = 1'b1; ab[d] = 1'b0; rm_in = rm;
        #1;
        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 4'b0000, last_rm[d], 3'd0};
        n_checks++;
        if (obs(d) !== exp_v) begin
            n_fail++;
            $display("FAIL op_accept dut%0d: got %h expected %h", d, obs(d), exp_v);
        end
        last_rm[d] = rm;
        for (int t = 1; t <= last; t++) begin
            @(posedge clk); #1;
            rm_in = 2'($urandom);
            st[d] = (t <= body + 1 && !(abort_t >= 0 && t > abort_t)) ? 1'($urandom) : 1'b0;
            ab[d] = (t == abort_t) || (t == body + 1 && 1'($urandom) == 1'b1);
            #1;
            if ((abort_t >= 0 && t > abort_t) || t > body + 1) begin
                exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0000, rm, 3'd0};
            end else if (t <= body) begin
                u = t - 1;
                e = step_info(itr, u / (ml + 1));
                exp_v = {1'b0, 1'b1, 1'b0, 1'b0, e[10:7],
                         ((u % (ml + 1)) == ml) ? e[6:3] : 4'b0000, rm, e[2:0]};
            end else begin
                exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 4'b0000, rm, 3'd0};
            end
            n_checks++;
            if (obs(d) !== exp_v) begin
                n_fail++;
                $display("FAIL op_cycle dut%0d t=%0d abort_t=%0d: got %h expected %h",
                         d, t, abort_t, obs(d), exp_v);
            end
        end
        st[d] = 1'b0; ab[d] = 1'b0;
    endtask

    task automatic test_abort_wins();
        @(posedge clk); #1;
        st[0] = 1'b1; ab[0] = 1'b1; rm_in = 2'b11;
        #1;
        n_checks++;
        if (ldo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wins_ld: got %b expected 0", ldo[0]);
        end
        @(posedge clk); #1;
        st[0] = 1'b0; ab[0] = 1'b0;
        #1;
        n_checks++;
        if (obs(0) !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0000, last_rm[0], 3'd0}) begin
            n_fail++;
            $display("FAIL abort_wins_idle: got %h expected ready idle rm=%0d", obs(0), last_rm[0]);
        end
    endtask

    // start held for 40 cycles: accepts at 0 and 22 (DONE at 21, re-accept in the next IDLE cycle).
    task automatic test_back_to_back();
        int lds[$];
        int dns[$];
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            rm_in = 2'b11;
            st[0] = (c < 40);
            #1;
            if (ldo[0] === 1'b1) lds.push_back(c);
            if (dn[0] === 1'b1) dns.push_back(c);
        end
        st[0] = 1'b0;
        last_rm[0] = 2'b11;
        n_checks++;
        if (lds.size() != 2 || lds[0] != 0 || lds[1] != 22) begin
            n_fail++;
            $display("FAIL back_to_back_accepts: got %0d accepts (first %0d, second %0d) expected 2 at 0,22",
                     lds.size(), lds.size() > 0 ? lds[0] : -1, lds.size() > 1 ? lds[1] : -1);
        end
        n_checks++;
        if (dns.size() != 2 || dns[0] != 21 || dns[1] != 43) begin
            n_fail++;
            $display("FAIL back_to_back_done: got %0d done pulses (first %0d, second %0d) expected 2 at 21,43",
                     dns.size(), dns.size() > 0 ? dns[0] : -1, dns.size() > 1 ? dns[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        st[0] = 1'b1; rm_in = 2'b10;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset_mid dut%0d: got %h expected %h", d, obs(d), RST_VEC);
            end
        end
        #2 reset = 1'b0;
        last_rm[0] = 2'b00;
        last_rm[1] = 2'b00;
    endtask

    initial begin
        int d;
        int abt;
        st[0] = 1'b0; st[1] = 1'b0; ab[0] = 1'b0; ab[1] = 1'b0; rm_in = 2'b00;
        last_rm[0] = 2'b00; last_rm[1] = 2'b00;
        test_reset();
        test_operation(0, 2'b01, -1);
        test_operation(1, 2'b00, -1);
        test_operation(0, 2'b10, 12);
        test_abort_wins();
        test_back_to_back();
        test_reset_mid();
        test_operation(0, 2'b11, -1);
        for (int k = 0; k < 8; k++) begin
            d   = int'($urandom_range(0, 1));
            abt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (d != 0) ? 24 : 20)) : -1;
            test_operation(d, 2'(k), abt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
